// File: rtl/edge_window_monitor.sv
// edge_window_monitor: edge detector on a, with a b-response window check.
// Optional macro EDGE_WINDOW_MONITOR_FELL_EN enables the fell_o pulse.
module edge_window_monitor #(
   parameter int WINDOW = 4,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             clr,
   output logic             rose_o,
   output logic             fell_o,
   output logic             pass_o,
   output logic             fail_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] rose_cnt,
   output logic [CNT_W-1:0] fail_cnt
);

   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [3:0] LAST = 4'(WINDOW - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_timer;
   logic [3:0] w_timer_nxt;
   logic       r_a_prev;
   logic       w_rise;
   logic       w_pass;
   logic       w_fail;

   assign w_rise = a & ~r_a_prev;
   assign busy_o = (r_state == WAIT);

   // state register and timer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_timer <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
      end
   end

   // next state: window timing, pass/fail decision, back-to-back reopen
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_pass      = 1'b0;
      w_fail      = 1'b0;
      if (clr) begin
         w_state_nxt = IDLE;
         w_timer_nxt = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_rise) begin
                  w_state_nxt = WAIT;
                  w_timer_nxt = '0;
               end
            end
            WAIT: begin
               if (b) begin
                  w_pass      = 1'b1;
                  w_state_nxt = IDLE;
                  w_timer_nxt = '0;
               end else if (r_timer == LAST) begin
                  w_fail      = 1'b1;
                  w_state_nxt = IDLE;
                  w_timer_nxt = '0;
               end else begin
                  w_timer_nxt = r_timer + 4'd1;
               end
               // a rise on the closing edge starts the next window at once
               if ((w_pass | w_fail) && w_rise) begin
                  w_state_nxt = WAIT;
                  w_timer_nxt = '0;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_timer_nxt = '0;
            end
         endcase
      end
   end

   // edge history and registered pulse outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a_prev <= 1'b0;
         rose_o   <= 1'b0;
         pass_o   <= 1'b0;
         fail_o   <= 1'b0;
      end else begin
         r_a_prev <= a;
         rose_o   <= w_rise;
         pass_o   <= w_pass;
         fail_o   <= w_fail;
      end
   end

`ifdef EDGE_WINDOW_MONITOR_FELL_EN
   logic r_fell;

   // falling-edge pulse
   always_ff @(posedge clk) begin
      if (!rst_n) r_fell <= 1'b0;
      else        r_fell <= ~a & r_a_prev;
   end

   assign fell_o = r_fell;
`else
   assign fell_o = 1'b0;
`endif

   // saturating event counters, cleared by clr
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rose_cnt <= '0;
         fail_cnt <= '0;
      end else if (clr) begin
         rose_cnt <= '0;
         fail_cnt <= '0;
      end else begin
         if (w_rise && rose_cnt != '1) rose_cnt <= rose_cnt + 1'b1;
         if (w_fail && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      end
   end

endmodule
